bcd_seg_display: RTL

Parametrised successor to the two-digit score display. It converts a WIDTH-bit unsigned binary value into DIGITS decimal digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock. It then drives one static 7-segment pattern per digit, with optional leading-zero blanking and an overflow indication. It sits between the game/score logic and the board's HEX displays, and replaces fixed-range combinational decoding for any value width.

---
 rtl/bcd_seg_display.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_seg_display.sv
// Binary-to-BCD (shift-add-3, one bit per clock) feeding per-digit static 7-segment patterns.
// Latency: WIDTH+1 cycles from the accepting load edge to valid seg/overflow (done pulse).
// Backpressure: none; load is accepted only in IDLE and ignored (not queued) while busy.
module bcd_seg_display #(
    parameter int WIDTH      = 8,
    parameter int DIGITS     = 3,
    parameter int ACTIVE_LOW = 1,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    // Segment pattern for an all-dark digit at the pins.
    localparam logic [6:0] BLANK_PAT = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t                 state;
    logic [WIDTH-1:0]       bin;
    logic [BW-1:0]          bcd;
    logic [BW-1:0]          bcd_adj;
    logic [BW+WIDTH-1:0]    shifted;
    logic [CW-1:0]          cnt;
    logic                   ovf_sticky;
    logic [7*DIGITS-1:0]    seg_next;
    logic [3:0]             nib;
    logic [6:0]             pat;
    logic                   lead;

    // Active-high {g,f,e,d,c,b,a} pattern for one decimal digit.
    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'b0111111;
            4'd1:    dec7 = 7'b0000110;
            4'd2:    dec7 = 7'b1011011;
            4'd3:    dec7 = 7'b1001111;
            4'd4:    dec7 = 7'b1100110;
            4'd5:    dec7 = 7'b1101101;
            4'd6:    dec7 = 7'b1111101;
            4'd7:    dec7 = 7'b0000111;
            4'd8:    dec7 = 7'b1111111;
            4'd9:    dec7 = 7'b1101111;
            default: dec7 = 7'b0000000;
        endcase
    endfunction

    // Add 3 to every nibble >= 5 so the following left shift carries correctly into the next digit.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin} << 1;
    end

    // Decode nibbles top-down so leading-zero status is known when each digit is reached.
    always_comb begin
        seg_next = '0;
        lead     = 1'b1;
        nib      = 4'd0;
        pat      = 7'd0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = bcd[4*i +: 4];
            if (nib != 4'd0) begin
                lead = 1'b0;
            end
            pat = dec7(nib);
            if (ovf_sticky) begin
                pat = 7'b1000000;
            end else if ((BLANK_LZ != 0) && lead && (i != 0)) begin
                pat = 7'b0000000;
            end
            seg_next[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
        end
    end

    // Control FSM, conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            seg        <= {DIGITS{BLANK_PAT}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        bin        <= value;
                        bcd        <= '0;
                        ovf_sticky <= 1'b0;
                        cnt        <= CW'(WIDTH);
                        busy       <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= shifted;
                    // A carry out of the top digit means the value needs more digits than we drive.
                    if (bcd_adj[BW-1]) begin
                        ovf_sticky <= 1'b1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    seg      <= seg_next;
                    overflow <= ovf_sticky;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
